// File: rtl/pipe_mux_sel_if.sv
// Handshake bundle for pipe_mux_sel: request side (in_*) and result side (out_*).
// master = producer/consumer environment, slave = the selector stage.
interface pipe_mux_sel_if #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 16,
  parameter int SEL_W  = 4
);
  logic                    in_valid;
  logic                    in_ready;
  logic [SEL_W-1:0]        in_sel;
  logic [NUM_IN*WIDTH-1:0] in_data;
  logic                    out_valid;
  logic                    out_ready;
  logic [WIDTH-1:0]        out_data;
  logic [SEL_W-1:0]        out_sel;
  logic                    out_err;

  modport master (
    output in_valid, in_sel, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_sel, out_err
  );

  modport slave (
    input  in_valid, in_sel, in_data, out_ready,
    output in_ready, out_valid, out_data, out_sel, out_err
  );
endinterface

// File: rtl/pipe_mux_sel.sv
// Registered N:1 word selector with output register + one skid entry, so in_ready is a flop.
// Optional build macro PIPE_MUX_SEL_ZERO0_EN: index 0 reads as hard-wired zero.
module pipe_mux_sel #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 16,
  parameter int SEL_W  = 4
) (
  input  logic         clock,
  input  logic         reset_n,
  pipe_mux_sel_if.slave bus
);

`ifdef PIPE_MUX_SEL_ZERO0_EN
  localparam int FIRST_IDX = 1;
`else
  localparam int FIRST_IDX = 0;
`endif
  localparam logic [SEL_W:0] NUM_IN_W = (SEL_W+1)'(NUM_IN);

  logic [WIDTH-1:0] w_words [FIRST_IDX:NUM_IN-1];
  logic [WIDTH-1:0] w_word;
  logic             w_err;
  logic             w_accept;
  logic             w_xfer;
  logic             w_or_free;
  logic             w_sk_valid_next;

  logic             r_or_valid;
  logic [WIDTH-1:0] r_or_data;
  logic [SEL_W-1:0] r_or_sel;
  logic             r_or_err;
  logic             r_sk_valid;
  logic [WIDTH-1:0] r_sk_data;
  logic [SEL_W-1:0] r_sk_sel;
  logic             r_sk_err;
  logic             r_in_ready;

  genvar gi;
  generate
    for (gi = FIRST_IDX; gi < NUM_IN; gi++) begin : g_word
      assign w_words[gi] = bus.in_data[gi*WIDTH +: WIDTH];
    end
  endgenerate

  // Only legal indices are decoded, so out-of-range selects never touch in_data and give 0.
  always_comb begin
    w_word = '0;
    for (int k = FIRST_IDX; k < NUM_IN; k++) begin
      if (bus.in_sel == SEL_W'(k)) begin
        w_word = w_words[k];
      end
    end
  end

  assign w_err     = ({1'b0, bus.in_sel} >= NUM_IN_W);
  assign w_accept  = bus.in_valid && r_in_ready;
  assign w_xfer    = r_or_valid && bus.out_ready;
  assign w_or_free = !r_or_valid || w_xfer;

  always_comb begin
    w_sk_valid_next = r_sk_valid;
    if (w_or_free) begin
      w_sk_valid_next = r_sk_valid && w_accept;
    end else if (w_accept) begin
      w_sk_valid_next = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_or_valid <= 1'b0;
      r_or_data  <= '0;
      r_or_sel   <= '0;
      r_or_err   <= 1'b0;
      r_sk_valid <= 1'b0;
      r_sk_data  <= '0;
      r_sk_sel   <= '0;
      r_sk_err   <= 1'b0;
      r_in_ready <= 1'b1;
    end else begin
      if (w_or_free) begin
        if (r_sk_valid) begin
          // Oldest entry lives in the skid; promote it to keep FIFO order.
          r_or_valid <= 1'b1;
          r_or_data  <= r_sk_data;
          r_or_sel   <= r_sk_sel;
          r_or_err   <= r_sk_err;
          if (w_accept) begin
            r_sk_data <= w_word;
            r_sk_sel  <= bus.in_sel;
            r_sk_err  <= w_err;
          end
        end else begin
          r_or_valid <= w_accept;
          if (w_accept) begin
            r_or_data <= w_word;
            r_or_sel  <= bus.in_sel;
            r_or_err  <= w_err;
          end
        end
      end else if (w_accept) begin
        r_sk_data <= w_word;
        r_sk_sel  <= bus.in_sel;
        r_sk_err  <= w_err;
      end
      r_sk_valid <= w_sk_valid_next;
      r_in_ready <= !w_sk_valid_next;
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_or_valid;
  assign bus.out_data  = r_or_data;
  assign bus.out_sel   = r_or_sel;
  assign bus.out_err   = r_or_err;

endmodule

// File: tb/tb_pipe_mux_sel.sv
// Scoreboard bench for pipe_mux_sel: a 16-input instance for the main traffic and a
// 10-input instance for out-of-range selects.
module tb_pipe_mux_sel;
  localparam int W  = 32;
  localparam int NA = 16;
  localparam int NB = 10;
  localparam int S  = 4;

  typedef struct {
    logic [W-1:0] data;
    logic [S-1:0] sel;
    logic         err;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pipe_mux_sel_if #(.WIDTH(W), .NUM_IN(NA), .SEL_W(S)) bus_a ();
  pipe_mux_sel_if #(.WIDTH(W), .NUM_IN(NB), .SEL_W(S)) bus_b ();

  pipe_mux_sel #(.WIDTH(W), .NUM_IN(NA), .SEL_W(S)) dut_a (
    .clock(clk), .reset_n(rst_n), .bus(bus_a)
  );
  pipe_mux_sel #(.WIDTH(W), .NUM_IN(NB), .SEL_W(S)) dut_b (
    .clock(clk), .reset_n(rst_n), .bus(bus_b)
  );

  exp_t q_a[$];
  exp_t q_b[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [S-1:0] sel, input logic [NA*W-1:0] data, input int n);
    exp_t e;
    e.sel  = sel;
    e.err  = (int'(sel) >= n);
    e.data = e.err ? '0 : data[int'(sel)*W +: W];
`ifdef PIPE_MUX_SEL_ZERO0_EN
    if (sel == '0) e.data = '0;
`endif
    return e;
  endfunction

  // Monitors on the falling edge: pop on transfer, push on accept.
  logic [W+S:0] stall_a;
  logic         stalled_a = 1'b0;
  always @(negedge clk) begin : mon_a
    exp_t e;
    if (!rst_n) begin
      stalled_a <= 1'b0;
    end else begin
      if (bus_a.out_valid && stalled_a)
        check("stable_a", 64'({bus_a.out_data, bus_a.out_sel, bus_a.out_err}), 64'(stall_a));
      if (bus_a.out_valid && bus_a.out_ready) begin
        check("expected_a", 64'(q_a.size() != 0), 64'(1));
        if (q_a.size() != 0) begin
          e = q_a.pop_front();
          $display("A out sel=%0d data=%08h err=%0b (exp sel=%0d data=%08h err=%0b)",
                   bus_a.out_sel, bus_a.out_data, bus_a.out_err, e.sel, e.data, e.err);
          check("data_a", 64'(bus_a.out_data), 64'(e.data));
          check("sel_a", 64'(bus_a.out_sel), 64'(e.sel));
          check("err_a", 64'(bus_a.out_err), 64'(e.err));
        end
      end
      stalled_a <= bus_a.out_valid && !bus_a.out_ready;
      stall_a   <= {bus_a.out_data, bus_a.out_sel, bus_a.out_err};
      if (bus_a.in_valid && bus_a.in_ready) q_a.push_back(model(bus_a.in_sel, bus_a.in_data, NA));
    end
  end

  always @(negedge clk) begin : mon_b
    exp_t e;
    if (rst_n) begin
      if (bus_b.out_valid && bus_b.out_ready) begin
        check("expected_b", 64'(q_b.size() != 0), 64'(1));
        if (q_b.size() != 0) begin
          e = q_b.pop_front();
          $display("B out sel=%0d data=%08h err=%0b (exp sel=%0d data=%08h err=%0b)",
                   bus_b.out_sel, bus_b.out_data, bus_b.out_err, e.sel, e.data, e.err);
          check("data_b", 64'(bus_b.out_data), 64'(e.data));
          check("sel_b", 64'(bus_b.out_sel), 64'(e.sel));
          check("err_b", 64'(bus_b.out_err), 64'(e.err));
        end
      end
      if (bus_b.in_valid && bus_b.in_ready)
        q_b.push_back(model(bus_b.in_sel, (NA*W)'(bus_b.in_data), NB));
    end
  end

  // Holds in_valid until accepted (bounded); leaves in_valid high for back-to-back use.
  task automatic send_a(input logic [S-1:0] sel);
    logic acc;
    int   cnt;
    bus_a.in_valid = 1'b1;
    bus_a.in_sel   = sel;
    acc = 1'b0;
    cnt = 0;
    while (!acc && cnt < 50) begin
      @(negedge clk);
      acc = bus_a.in_ready;
      @(posedge clk);
      #1;
      cnt++;
    end
    check("accept_a", 64'(acc), 64'(1));
  endtask

  task automatic send_b(input logic [S-1:0] sel);
    logic acc;
    int   cnt;
    bus_b.in_valid = 1'b1;
    bus_b.in_sel   = sel;
    acc = 1'b0;
    cnt = 0;
    while (!acc && cnt < 50) begin
      @(negedge clk);
      acc = bus_b.in_ready;
      @(posedge clk);
      #1;
      cnt++;
    end
    bus_b.in_valid = 1'b0;
    check("accept_b", 64'(acc), 64'(1));
  endtask

  task automatic drain(input int max_cyc);
    int cnt;
    cnt = 0;
    while ((q_a.size() != 0 || q_b.size() != 0) && cnt < max_cyc) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    check("drain", 64'(q_a.size() + q_b.size()), 64'(0));
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    bus_a.in_valid = 1'b0; bus_a.in_sel = '0; bus_a.out_ready = 1'b1;
    bus_b.in_valid = 1'b0; bus_b.in_sel = '0; bus_b.out_ready = 1'b1;
    for (int k = 0; k < NA; k++) bus_a.in_data[k*W +: W] = 32'hA000_0000 + 32'(k);
    for (int k = 0; k < NB; k++) bus_b.in_data[k*W +: W] = 32'hB000_0000 + 32'(k);

    #12;
    check("rst_valid", 64'(bus_a.out_valid), 64'(0));
    check("rst_ready", 64'(bus_a.in_ready), 64'(1));
    check("rst_data", 64'(bus_a.out_data), 64'(0));
    check("rst_sel", 64'(bus_a.out_sel), 64'(0));
    check("rst_err", 64'(bus_a.out_err), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Streaming: results on consecutive cycles starting one cycle after first accept.
    for (int k = 0; k < NA; k++) begin
      send_a(4'(k));
      check("stream_valid", 64'(bus_a.out_valid), 64'(1));
      check("stream_ready", 64'(bus_a.in_ready), 64'(1));
    end
    bus_a.in_valid = 1'b0;
    drain(20);

    // Back-pressure: two fit (OR + skid), third held off.
    bus_a.out_ready = 1'b0;
    send_a(4'd3);
    send_a(4'd5);
    check("bp_ready_low", 64'(bus_a.in_ready), 64'(0));
    bus_a.in_sel = 4'd7;
    repeat (3) begin
      @(posedge clk); #1;
      check("bp_held", 64'(q_a.size()), 64'(2));
      check("bp_ready_held", 64'(bus_a.in_ready), 64'(0));
    end
    bus_a.out_ready = 1'b1;
    send_a(4'd7);
    bus_a.in_valid = 1'b0;
    drain(20);

    // Data sampled only at the accept edge.
    bus_a.in_data[2*W +: W] = 32'h1234_5678;
    send_a(4'd2);
    bus_a.in_valid = 1'b0;
    bus_a.in_data[2*W +: W] = 32'hFFFF_0000;
    drain(20);

    // Word 0 behaviour depends on the build option.
    bus_a.in_data[0 +: W] = 32'hDEAD_BEEF;
    send_a(4'd0);
    bus_a.in_valid = 1'b0;
    @(negedge clk);
`ifdef PIPE_MUX_SEL_ZERO0_EN
    check("zero0_data", 64'(bus_a.out_data), 64'(0));
`else
    check("word0_data", 64'(bus_a.out_data), 64'(32'hDEAD_BEEF));
`endif
    check("word0_err", 64'(bus_a.out_err), 64'(0));
    drain(20);

    // Out of range on the 10-input instance.
    send_b(4'd12);
    @(negedge clk);
    check("oor_data", 64'(bus_b.out_data), 64'(0));
    check("oor_err", 64'(bus_b.out_err), 64'(1));
    check("oor_sel", 64'(bus_b.out_sel), 64'(12));
    send_b(4'd9);
    @(negedge clk);
    check("last_err", 64'(bus_b.out_err), 64'(0));
    check("last_data", 64'(bus_b.out_data), 64'(32'hB000_0009));
    send_b(4'd15);
    drain(20);

    // Asynchronous reset with both entries full.
    bus_a.out_ready = 1'b0;
    send_a(4'd1);
    send_a(4'd4);
    bus_a.in_valid = 1'b0;
    check("full_ready", 64'(bus_a.in_ready), 64'(0));
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", 64'(bus_a.out_valid), 64'(0));
    check("arst_ready", 64'(bus_a.in_ready), 64'(1));
    check("arst_data", 64'(bus_a.out_data), 64'(0));
    q_a.delete();
    q_b.delete();
    @(negedge clk);
    rst_n = 1'b1;
    bus_a.out_ready = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      check("post_rst_valid", 64'(bus_a.out_valid), 64'(0));
    end

    // Streaming still works after reset.
    send_a(4'd6);
    send_a(4'd11);
    bus_a.in_valid = 1'b0;
    drain(20);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule

// File: doc/pipe_mux_sel.md
Name: pipe_mux_sel

Overview:
- Parametrised, registered N:1 word selector with a valid/ready handshake on both sides; generalises the 16:1 x 32-bit register read selector.
- Sits between the register file's flattened read bus and the execute-stage operand latch.
- Lets the operand path stall without dropping a selection.
- A two-entry skid buffer keeps in_ready a pure register output, so no combinational ready path crosses the stage.

Parameters:
- WIDTH, 32, bits per input word and per out_data.
- NUM_IN, 16, number of input words; legal range 2..64, need not be a power of two.
- SEL_W, 4, width of in_sel; must satisfy 2**SEL_W >= NUM_IN.

Ports:
- clock  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  request present.
- in_ready  output  1  stage can accept a request this cycle.
- in_sel  input  SEL_W  index of the word to select.
- in_data  input  NUM_IN*WIDTH  flattened words; word k = in_data[k*WIDTH +: WIDTH].
- out_valid  output  1  out_data/out_sel/out_err hold a result.
- out_ready  input  1  consumer accepts the result this cycle.
- out_data  output  WIDTH  selected word.
- out_sel  output  SEL_W  index that produced out_data.
- out_err  output  1  in_sel was >= NUM_IN.

Behaviour:
- Reset (asynchronous assert, synchronous release): out_valid=0, out_data=0, out_sel=0, out_err=0, skid empty, in_ready=1.
- Input accept: when in_valid && in_ready at a rising edge.
  - Capture word in_data[in_sel], in_sel, and err = (in_sel >= NUM_IN).
  - If err: word = 0.
  - in_data is sampled only on that edge; later changes have no effect.
- Latency: accepted request appears on the outputs on the next cycle.
  - Throughput is 1 per cycle while out_ready=1.
- Output transfer: when out_valid && out_ready.
- Storage: output register (OR) plus skid register (SK).
  - Accept and OR empty or being transferred: load OR from the input.
  - Else if SK holds data and OR is transferring: OR <- SK and the new accept goes to SK.
  - Accept while OR full and not transferring: load SK.
  - in_ready next = !(SK full after this edge). Registered, never depends combinationally on out_ready.
- Full condition: OR and SK both full, so in_ready=0. in_valid is ignored; no capture, no overwrite.
- Empty condition: out_valid=0. out_data holds its last value (don't-care for the consumer).
- Ordering: strictly FIFO; results leave in accept order.
- Output stability: while out_valid && !out_ready, out_data, out_sel and out_err stay stable.
- Simultaneous accept + transfer with SK full: SK->OR, input->SK, in_ready stays 0 only if SK is still full.
- Reset mid-operation: both entries discarded immediately; no partial result is emitted after reset_n rises.
- Non-power-of-two NUM_IN: out-of-range indices never read beyond in_data; result is 0 with out_err=1.

Optional Feature:
- Macro: PIPE_MUX_SEL_ZERO0_EN.
- Defined: index 0 is hard-wired zero.
  - A request with in_sel=0 yields out_data=0 regardless of in_data word 0.
  - out_err=0 for that request.
  - Word 0 of in_data is not sampled.
- Undefined: index 0 selects in_data word 0 like any other index.
- Handshake and latency are identical in both builds.

Test Plan:
- Streaming: out_ready=1; issue sel 0..15 back-to-back with word k = 32'hA000_0000+k. Expect out_data A000_0000..A000_000F on consecutive cycles starting one cycle after the first accept; in_ready stays 1.
- Back-pressure: out_ready=0; offer three requests (sel 3, 5, 7). Expect the first two accepted, in_ready=0 after the second, the third held off. Then raise out_ready: expect outputs 3, 5, 7 in order with no loss or duplication.
- Out of range: NUM_IN=10, SEL_W=4, in_sel=12. Expect out_data=0, out_err=1, out_sel=12; the next request with sel=9 gives out_err=0.
- Data sampling: change in_data the cycle after accepting sel=2. Expect out_data to equal the word 2 value present at the accept edge.
- Reset: assert reset_n=0 with OR and SK full. Expect out_valid=0, in_ready=1, out_data=0 immediately (asynchronous), and no result after release.
- Zero-0 build: define PIPE_MUX_SEL_ZERO0_EN, word 0 = 32'hDEAD_BEEF, sel=0. Expect out_data=0, out_err=0. Without the macro, expect out_data=DEAD_BEEF.
